// File: rtl/cosine_inverse_pkg.sv
// Shared microstepper constants for the cosine table and its inverse search.
package cosine_inverse_pkg;

  localparam int COS_DEPTH = 64;
  localparam int COS_IDX_W = 6;
  localparam int COS_VAL_W = 8;
  localparam int COS_MIN   = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // A count of 64 means every entry exceeds the value; the index pins to the last entry.
  function automatic logic [COS_IDX_W-1:0] clamp_index(input logic [COS_IDX_W:0] count);
    if (count[COS_IDX_W]) begin
      clamp_index = 6'd63;
    end else begin
      clamp_index = count[COS_IDX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/cosine_inverse_if.sv
// Request/result handshake bundle between a requester and cosine_inverse.
interface cosine_inverse_if;
  import cosine_inverse_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [COS_VAL_W-1:0] in_value;
  logic                 in_sign;
  logic                 out_valid;
  logic                 out_ready;
  logic [COS_IDX_W:0]   out_index;
  logic                 out_sat;

  modport master (
    output in_valid, in_value, in_sign, out_ready,
    input  in_ready, out_valid, out_index, out_sat
  );

  modport slave (
    input  in_valid, in_value, in_sign, out_ready,
    output in_ready, out_valid, out_index, out_sat
  );

endinterface

// File: rtl/cosine_inverse_cosine.sv
// Microstepper quarter-wave cosine table: round(255*cos(i*pi/128)), i = 0..63.
// Monotone non-increasing, minimum entry 6 at index 63. Purely combinational.
module cosine
  import cosine_inverse_pkg::*;
(
  input  logic [COS_IDX_W-1:0] addr,
  output logic [COS_VAL_W-1:0] value
);

  // Table lookup.
  always_comb begin
    value = 8'd0;
    case (addr)
      6'd0:  value = 8'd255;
      6'd1:  value = 8'd255;
      6'd2:  value = 8'd255;
      6'd3:  value = 8'd254;
      6'd4:  value = 8'd254;
      6'd5:  value = 8'd253;
      6'd6:  value = 8'd252;
      6'd7:  value = 8'd251;
      6'd8:  value = 8'd250;
      6'd9:  value = 8'd249;
      6'd10: value = 8'd247;
      6'd11: value = 8'd246;
      6'd12: value = 8'd244;
      6'd13: value = 8'd242;
      6'd14: value = 8'd240;
      6'd15: value = 8'd238;
      6'd16: value = 8'd236;
      6'd17: value = 8'd233;
      6'd18: value = 8'd231;
      6'd19: value = 8'd228;
      6'd20: value = 8'd225;
      6'd21: value = 8'd222;
      6'd22: value = 8'd219;
      6'd23: value = 8'd215;
      6'd24: value = 8'd212;
      6'd25: value = 8'd208;
      6'd26: value = 8'd205;
      6'd27: value = 8'd201;
      6'd28: value = 8'd197;
      6'd29: value = 8'd193;
      6'd30: value = 8'd189;
      6'd31: value = 8'd185;
      6'd32: value = 8'd180;
      6'd33: value = 8'd176;
      6'd34: value = 8'd171;
      6'd35: value = 8'd167;
      6'd36: value = 8'd162;
      6'd37: value = 8'd157;
      6'd38: value = 8'd152;
      6'd39: value = 8'd147;
      6'd40: value = 8'd142;
      6'd41: value = 8'd136;
      6'd42: value = 8'd131;
      6'd43: value = 8'd126;
      6'd44: value = 8'd120;
      6'd45: value = 8'd115;
      6'd46: value = 8'd109;
      6'd47: value = 8'd103;
      6'd48: value = 8'd98;
      6'd49: value = 8'd92;
      6'd50: value = 8'd86;
      6'd51: value = 8'd80;
      6'd52: value = 8'd74;
      6'd53: value = 8'd68;
      6'd54: value = 8'd62;
      6'd55: value = 8'd56;
      6'd56: value = 8'd50;
      6'd57: value = 8'd44;
      6'd58: value = 8'd37;
      6'd59: value = 8'd31;
      6'd60: value = 8'd25;
      6'd61: value = 8'd19;
      6'd62: value = 8'd13;
      6'd63: value = 8'd6;
      default: value = 8'd6;
    endcase
  end

endmodule

// File: rtl/cosine_inverse.sv
// Inverse cosine lookup: successive-approximation search over the cosine table
// that counts entries greater than the requested magnitude (7 search cycles).
// Optional feature macro COSINE_INVERSE_QUADRANT_EN mirrors the index into the
// second quarter period when in_sign is set.
module cosine_inverse
  import cosine_inverse_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  cosine_inverse_if.slave  bus
);

  state_t               state_r;
  logic [COS_VAL_W-1:0] value_r;
  logic [COS_IDX_W:0]   acc_r;
  logic [2:0]           bit_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [COS_IDX_W:0]   out_index_r;
  logic                 out_sat_r;
`ifdef COSINE_INVERSE_QUADRANT_EN
  logic                 sign_r;
`else
  logic                 unused_sign_s;
  assign unused_sign_s = bus.in_sign;
`endif

  logic [COS_IDX_W:0]   trial_s;
  logic                 in_range_s;
  logic [COS_IDX_W-1:0] addr_s;
  logic [COS_VAL_W-1:0] entry_s;
  logic [COS_IDX_W:0]   acc_next_s;
  logic [COS_IDX_W-1:0] idx6_s;
  logic [COS_IDX_W:0]   index_s;

  cosine u_cosine (
    .addr  (addr_s),
    .value (entry_s)
  );

  // Probe the table at trial count t (address t-1) and keep t if that entry still exceeds the value.
  always_comb begin
    trial_s    = acc_r | (7'd1 << bit_r);
    in_range_s = (trial_s <= 7'd64);
    addr_s     = trial_s[COS_IDX_W-1:0] - 6'd1;
    if (in_range_s && (entry_s > value_r)) begin
      acc_next_s = trial_s;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Final index from the completed count, optionally mirrored by the latched sign.
  always_comb begin
    idx6_s  = clamp_index(acc_next_s);
    index_s = {1'b0, idx6_s};
`ifdef COSINE_INVERSE_QUADRANT_EN
    if (sign_r) begin
      index_s = 7'd127 - {1'b0, idx6_s};
    end else begin
      index_s = {1'b0, idx6_s};
    end
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      value_r     <= 8'd0;
      acc_r       <= 7'd0;
      bit_r       <= 3'd6;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_index_r <= 7'd0;
      out_sat_r   <= 1'b0;
`ifdef COSINE_INVERSE_QUADRANT_EN
      sign_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            value_r    <= bus.in_value;
`ifdef COSINE_INVERSE_QUADRANT_EN
            sign_r     <= bus.in_sign;
`endif
            acc_r      <= 7'd0;
            bit_r      <= 3'd6;
            in_ready_r <= 1'b0;
            state_r    <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          acc_r <= acc_next_s;
          if (bit_r == 3'd0) begin
            out_index_r <= index_s;
            out_sat_r   <= (acc_next_s == 7'd64);
            out_valid_r <= 1'b1;
            state_r     <= ST_HOLD;
          end else begin
            bit_r <= bit_r - 3'd1;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_index = out_index_r;
  assign bus.out_sat   = out_sat_r;

endmodule

// File: tb/tb_cosine_inverse.sv
// Directed bench for cosine_inverse: reset, latency, table endpoints,
// backpressure, mid-search reset, sign handling and a full value sweep.
module tb_cosine_inverse;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cosine_inverse_if bus_if ();

  cosine_inverse dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference table: round(255*cos(i*pi/128)).
  function automatic int tab_val(input int i);
    return int'(255.0 * $cos(3.141592653589793 * real'(i) / 128.0));
  endfunction

  function automatic int count_gt(input int v);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      if (tab_val(i) > v) c++;
    end
    return c;
  endfunction

  function automatic int exp_index(input int idx6, input logic s);
`ifdef COSINE_INVERSE_QUADRANT_EN
    return s ? (127 - idx6) : idx6;
`else
    return idx6;
`endif
  endfunction

  // Called on a falling edge just after the accepting edge; counts edges until out_valid.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus_if.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic do_req(input string tag, input logic [7:0] v, input logic s,
                        input int exp_idx, input logic exp_sat);
    int lat;
    @(negedge clk);
    bus_if.in_value = v;
    bus_if.in_sign  = s;
    bus_if.in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'd7);
    check({tag, "_index"}, 32'(bus_if.out_index), 32'(exp_idx));
    check({tag, "_sat"}, 32'(bus_if.out_sat), 32'(exp_sat));
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check({tag, "_release"}, 32'(bus_if.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int c;
    checks = 0;
    errors = 0;
    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_value  = 8'd0;
    bus_if.in_sign   = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_out_index", 32'(bus_if.out_index), 32'd0);
    check("rst_out_sat", 32'(bus_if.out_sat), 32'd0);

    // Main value and table endpoints
    do_req("v180", 8'd180, 1'b0, 32, 1'b0);
    do_req("v255", 8'd255, 1'b0, 0, 1'b0);
    do_req("v254", 8'd254, 1'b0, 3, 1'b0);
    do_req("v100", 8'd100, 1'b0, 48, 1'b0);
    do_req("v6", 8'd6, 1'b0, 63, 1'b0);
    do_req("v3", 8'd3, 1'b0, 63, 1'b1);

    // Backpressure: result held while a new request waits
    @(negedge clk);
    bus_if.in_value = 8'd100;
    bus_if.in_sign  = 1'b0;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_value = 8'd255;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd7);
    for (int k = 0; k < 20; k++) begin
      check("bp_valid", 32'(bus_if.out_valid), 32'd1);
      check("bp_index", 32'(bus_if.out_index), 32'd48);
      check("bp_sat", 32'(bus_if.out_sat), 32'd0);
      check("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check("bp_rel_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("bp_rel_valid", 32'(bus_if.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    check("bp_next_accepted", 32'(bus_if.in_ready), 32'd0);
    wait_valid(lat);
    check("bp_next_latency", 32'(lat), 32'd7);
    check("bp_next_index", 32'(bus_if.out_index), 32'd0);
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.out_ready = 1'b0;

    // Leave a nonzero index registered, then reset 3 cycles into SEARCH
    do_req("pre_rst", 8'd180, 1'b0, 32, 1'b0);
    @(negedge clk);
    bus_if.in_value = 8'd180;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("mid_rst_valid", 32'(bus_if.out_valid), 32'd0);
    check("mid_rst_index", 32'(bus_if.out_index), 32'd0);
    check("mid_rst_sat", 32'(bus_if.out_sat), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_no_valid", 32'(bus_if.out_valid), 32'd0);
    end
    do_req("post_rst_v255", 8'd255, 1'b0, 0, 1'b0);

    // Sign input: mirrored only when the quadrant feature is built in
    do_req("sign_v255", 8'd255, 1'b1, exp_index(0, 1'b1), 1'b0);
    do_req("sign_v180", 8'd180, 1'b1, exp_index(32, 1'b1), 1'b0);
    do_req("sign_v3", 8'd3, 1'b1, exp_index(63, 1'b1), 1'b1);

    // Full sweep against the counting model
    for (int v = 0; v < 256; v++) begin
      c = count_gt(v);
      do_req($sformatf("sweep_%0d", v), 8'(v), 1'b0, (c > 63) ? 63 : c, (c == 64));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cosine_inverse.md
# cosine_inverse

Inverse of the microstepper cosine table: turns a measured 8-bit phase-current magnitude into the 6-bit table index (electrical phase) that produces it. It sits beside the cosine table in the microstepper and feeds stall detection and phase-error estimation. The search is a sequential successive approximation over the existing `cosine` table, with valid/ready handshakes on both sides.

## Interface
- No parameters. Table depth 64 and index width 6 are fixed package constants.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request carries a valid `in_value`.
- `in_ready`  out  1  block can accept a request. High only in IDLE.
- `in_value`  in  8  magnitude to invert, 0–255.
- `in_sign`  in  1  sign of the measured current. Used only with `COSINE_INVERSE_QUADRANT_EN`; ignored otherwise.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer takes the result.
- `out_index`  out  7  resulting index. Bit 6 is 0 unless the quadrant feature is enabled.
- `out_sat`  out  1  `in_value` was below the table minimum (6); the index is saturated.

## Operation
- **Definition:** `c` = number of table entries `cos[i]` (i = 0..63) with `cos[i] > in_value`, range 0..64.
- `idx6 = min(c, 63)`.
- `out_sat = (c == 64)`.
- The result is exact because the table is monotone non-increasing. With duplicate entries, the result is the first index whose entry is ≤ the value.
- **States:** IDLE, SEARCH, HOLD.
  - IDLE: `in_ready=1`. On `in_valid`, latch `in_value` and `in_sign`, clear the 7-bit accumulator `c`, set bit pointer `b=6`, and go to SEARCH.
  - SEARCH: each cycle, form `t = c | (1<<b)`. If `t ≤ 64` and `cos[t-1] > value`, set `c = t`. Decrement `b`. After the `b=0` step, register the outputs and go to HOLD.
  - HOLD: `out_valid=1`, and the outputs are stable. On `out_ready`, go to IDLE.
- **Table address:** `t-1`, 6 bits. `t=0` never occurs.
- **Request overlap:** `in_valid` outside IDLE is not accepted; the requester holds its request. There is no queuing.
- **Reset:** reset in any state, including mid-SEARCH, returns to IDLE next edge and abandons the search.
- **Reset values:** `out_valid=0`, `out_index=0`, `out_sat=0`, `c=0`, `b=6`. `in_ready` reads 1 from the first cycle after reset deasserts.

## Timing
- Request accepted at edge N (`in_valid & in_ready`).
- SEARCH evaluates one bit on each of edges N+1..N+7.
- `out_valid` is high after edge N+7, i.e. 7 cycles of latency.
- Result accepted at edge M (`out_valid & out_ready`). `in_ready` is high after M, so the next request can be accepted at M+1.
- Minimum throughput: one result per 9 cycles with `out_ready` tied high.
- `in_ready` and `out_valid` are decoded from state only. There are no combinational paths from `in_valid` or `out_ready` to any output.
- The `cosine` lookup is combinational. The critical path is accumulator → table → 8-bit compare → accumulator, within one cycle.

## Configuration
- **`COSINE_INVERSE_QUADRANT_EN` defined:** output covers a half electrical period.
  - `out_index = in_sign ? 127 - idx6 : idx6`.
  - `out_sat` is unchanged.
- **Not defined:** `out_index = {1'b0, idx6}`, `in_sign` is unused, and no extra logic is generated.

## Structure
- Shared microstepper package/include holds:
  - `COS_DEPTH=64`
  - `COS_IDX_W=6`
  - `COS_VAL_W=8`
  - `COS_MIN=6`
  - the state encodings IDLE/SEARCH/HOLD
- One sub-module: instantiate the existing `cosine` table as the only lookup. Do not duplicate table contents.

## Test plan
- **Value 180:** `in_value=180`, sign 0 → `out_index=32`, `out_sat=0`, `out_valid` exactly 7 cycles after acceptance.
- **Table endpoints and saturation:**
  - values 255 / 254 / 100 / 6 / 3 → indices 0 / 3 / 48 / 63 / 63
  - `out_sat` = 0 / 0 / 0 / 0 / 1
- **Backpressure:** hold `out_ready=0` for 20 cycles with `in_valid` asserted → outputs stable, `in_ready=0`. Release → next request accepted the cycle after result acceptance.
- **Reset mid-operation:** reset asserted 3 cycles into SEARCH → `out_valid` never asserts, all outputs at reset values. A fresh request for value 255 then returns 0.
- **Quadrant enabled:** with `COSINE_INVERSE_QUADRANT_EN`, sign 1 and value 255 → 127; sign 1 and value 180 → 95. Without the macro, the same stimulus → 0 and 32.
- **Exhaustive sweep:** all 256 values vs. a model count of table entries greater than the value → exact `out_index` / `out_sat` match.
